// File: rtl/transport_pkg.sv
// Shared command codes, header layout and transmit FSM states for the transport packetizer.
package transport_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_CTRL  = 2'b01;
  localparam logic [1:0] CMD_AUDIO = 2'b10;
  localparam logic [1:0] CMD_FLUSH = 2'b11;

  localparam logic [1:0] TYPE_CTRL  = 2'b01;
  localparam logic [1:0] TYPE_AUDIO = 2'b10;

  localparam int unsigned SEQ_W = 6;

  typedef struct packed {
    logic [1:0]       pkt_type;
    logic [SEQ_W-1:0] seq;
  } pkt_hdr_t;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_HDR,
    ST_DEST,
    ST_PAYLOAD,
    ST_PAD
  } tx_state_t;

endpackage

// File: rtl/transport_word_buf.sv
// Audio frame buffer: word writes at a running index, byte-granular read (MSB byte first), index clear.
module transport_word_buf
  import transport_pkg::*;
#(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned AUDIO_WORDS = 7,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned IDX_W       = $clog2(AUDIO_WORDS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              clr_i,
  output logic [IDX_W-1:0]  idx_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_byte_o
);

  localparam int unsigned BPW = WORD_W / 8;
  localparam int unsigned NB  = AUDIO_WORDS * BPW;

  logic [NB-1:0][7:0] mem_q;
  logic [IDX_W-1:0]   idx_q;

  // Bytes are stored flattened so reads need no division by the word size.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      idx_q <= '0;
    end else begin
      if (wr_en_i) begin
        for (int w = 0; w < AUDIO_WORDS; w++) begin
          if (idx_q == IDX_W'(w)) begin
            for (int b = 0; b < BPW; b++) begin
              mem_q[w*BPW + b] <= wr_data_i[WORD_W-1-8*b -: 8];
            end
          end
        end
      end
      if (clr_i) begin
        idx_q <= '0;
      end else if (wr_en_i) begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    rd_byte_o = '0;
    for (int i = 0; i < NB; i++) begin
      if (rd_addr_i == ADDR_W'(i)) rd_byte_o = mem_q[i];
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/transport_packetizer.sv
// Builds fixed-length control/audio packets and streams them one byte per cycle with backpressure.
// Optional TRANSPORT_SEQ_EN puts a shared 6-bit sequence counter in the header.
module transport_packetizer
  import transport_pkg::*;
#(
  parameter int unsigned PACKET_BYTES = 16,
  parameter int unsigned WORD_W       = 16,
  parameter int unsigned AUDIO_WORDS  = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        phone_num,
  input  logic [1:0]        cmd,
  input  logic [WORD_W-1:0] data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int unsigned BPW   = WORD_W / 8;
  localparam int unsigned TAIL  = PACKET_BYTES - 2;
  localparam int unsigned NB    = AUDIO_WORDS * BPW;
  localparam int unsigned CNT_W = $clog2(PACKET_BYTES);
  localparam int unsigned IDX_W = $clog2(AUDIO_WORDS + 1);

  tx_state_t         state_q, state_d;
  logic              pkt_ctrl_q, pkt_ctrl_d;
  logic [CNT_W-1:0]  pay_len_q, pay_len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] ctrl_word_q, ctrl_word_d;
  logic [7:0]        ctrl_dest_q, ctrl_dest_d;
  logic [7:0]        audio_dest_q, audio_dest_d;
  logic [7:0]        out_byte_q, out_byte_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic [SEQ_W-1:0]  seq_q;

  logic              accept_c, hs_c, start_c;
  logic              buf_wr_c, buf_clr_c;
  logic [IDX_W-1:0]  buf_idx;
  logic [CNT_W-1:0]  rd_addr_c;
  logic [7:0]        buf_byte, ctrl_byte_c, pay_byte_c;
  pkt_hdr_t          hdr_c;

  assign accept_c = in_valid && in_ready_q;
  assign hs_c     = out_valid_q && out_ready;

  transport_word_buf #(
    .WORD_W     (WORD_W),
    .AUDIO_WORDS(AUDIO_WORDS),
    .ADDR_W     (CNT_W),
    .IDX_W      (IDX_W)
  ) u_word_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en_i  (buf_wr_c),
    .wr_data_i(data),
    .clr_i    (buf_clr_c),
    .idx_o    (buf_idx),
    .rd_addr_i(rd_addr_c),
    .rd_byte_o(buf_byte)
  );

  // Payload byte that will be presented after the current handshake.
  assign rd_addr_c = (state_q == ST_PAYLOAD) ? cnt_q + CNT_W'(1) : '0;

  always_comb begin
    ctrl_byte_c = '0;
    for (int b = 0; b < BPW; b++) begin
      if (rd_addr_c == CNT_W'(b)) ctrl_byte_c = ctrl_word_q[WORD_W-1-8*b -: 8];
    end
  end

  assign pay_byte_c = pkt_ctrl_q ? ctrl_byte_c : buf_byte;

`ifdef TRANSPORT_SEQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_q <= '0;
    end else if (state_q == ST_HDR && hs_c) begin
      seq_q <= seq_q + SEQ_W'(1);
    end
  end
`else
  assign seq_q = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_COLLECT;
      pkt_ctrl_q   <= 1'b0;
      pay_len_q    <= '0;
      cnt_q        <= '0;
      ctrl_word_q  <= '0;
      ctrl_dest_q  <= '0;
      audio_dest_q <= '0;
      out_byte_q   <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pkt_ctrl_q   <= pkt_ctrl_d;
      pay_len_q    <= pay_len_d;
      cnt_q        <= cnt_d;
      ctrl_word_q  <= ctrl_word_d;
      ctrl_dest_q  <= ctrl_dest_d;
      audio_dest_q <= audio_dest_d;
      out_byte_q   <= out_byte_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pkt_ctrl_d   = pkt_ctrl_q;
    pay_len_d    = pay_len_q;
    cnt_d        = cnt_q;
    ctrl_word_d  = ctrl_word_q;
    ctrl_dest_d  = ctrl_dest_q;
    audio_dest_d = audio_dest_q;
    out_byte_d   = out_byte_q;
    out_valid_d  = out_valid_q;
    buf_wr_c     = 1'b0;
    buf_clr_c    = 1'b0;
    start_c      = 1'b0;
    hdr_c        = '{pkt_type: TYPE_AUDIO, seq: seq_q};

    unique case (state_q)
      ST_COLLECT: begin
        if (accept_c) begin
          unique case (cmd)
            CMD_CTRL: begin
              ctrl_word_d    = data;
              ctrl_dest_d    = phone_num;
              pkt_ctrl_d     = 1'b1;
              pay_len_d      = CNT_W'(BPW);
              hdr_c.pkt_type = TYPE_CTRL;
              start_c        = 1'b1;
            end
            CMD_AUDIO: begin
              buf_wr_c = 1'b1;
              if (buf_idx == '0) audio_dest_d = phone_num;
              if (buf_idx == IDX_W'(AUDIO_WORDS - 1)) begin
                buf_clr_c  = 1'b1;
                pkt_ctrl_d = 1'b0;
                pay_len_d  = CNT_W'(NB);
                start_c    = 1'b1;
              end
            end
            CMD_FLUSH: begin
              if (buf_idx != '0) begin
                buf_clr_c  = 1'b1;
                pkt_ctrl_d = 1'b0;
                pay_len_d  = CNT_W'(32'(buf_idx) * BPW);
                start_c    = 1'b1;
              end
            end
            CMD_IDLE: ;
            default: ;
          endcase
        end
        if (start_c) begin
          state_d     = ST_HDR;
          out_valid_d = 1'b1;
          out_byte_d  = hdr_c;
        end
      end
      ST_HDR: begin
        if (hs_c) begin
          state_d    = ST_DEST;
          out_byte_d = pkt_ctrl_q ? ctrl_dest_q : audio_dest_q;
        end
      end
      ST_DEST: begin
        if (hs_c) begin
          cnt_d = '0;
          if (pay_len_q != '0) begin
            state_d    = ST_PAYLOAD;
            out_byte_d = pay_byte_c;
          end else begin
            state_d    = ST_PAD;
            out_byte_d = '0;
          end
        end
      end
      ST_PAYLOAD: begin
        if (hs_c) begin
          if (cnt_q == pay_len_q - CNT_W'(1)) begin
            if (pay_len_q == CNT_W'(TAIL)) begin
              state_d     = ST_COLLECT;
              out_valid_d = 1'b0;
            end else begin
              state_d    = ST_PAD;
              cnt_d      = cnt_q + CNT_W'(1);
              out_byte_d = '0;
            end
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            out_byte_d = pay_byte_c;
          end
        end
      end
      ST_PAD: begin
        if (hs_c) begin
          if (cnt_q == CNT_W'(TAIL - 1)) begin
            state_d     = ST_COLLECT;
            out_valid_d = 1'b0;
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            out_byte_d = '0;
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    in_ready_d = (state_d == ST_COLLECT);
    busy_d     = (state_d != ST_COLLECT);
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_byte  = out_byte_q;
  assign out_valid = out_valid_q;

endmodule
